// File: rtl/add_seq_n.sv
// Multi-cycle N-bit adder: adds K bits per clock with a registered carry between
// chunks, supports unsigned and two's-complement overflow, start/ready handshake.
module add_seq_n #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         sign_i,
  input  logic [N-1:0] data0_i,
  input  logic [N-1:0] data1_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic         over_o
);

  localparam int NC  = N / K;
  localparam int JW  = (NC > 1) ? $clog2(NC) : 1;
  localparam int KW1 = K + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N-1:0]  CHUNK_MASK = {N{1'b1}} >> (N - K);
  localparam logic [JW-1:0] J_LAST     = JW'(NC - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          sign_q, sign_d;
  logic          carry_q, carry_d;
  logic [JW-1:0] j_q, j_d;
  logic [N-1:0]  data_q, data_d;
  logic          over_q, over_d;

  logic [31:0]   shamt;
  logic [K-1:0]  a_chunk, b_chunk;
  logic [K:0]    sum_c;

  // Chunk j occupies bits [j*K +: K]; shifting keeps the select legal for any K.
  assign shamt   = 32'(j_q) * 32'(K);
  assign a_chunk = K'(a_q >> shamt);
  assign b_chunk = K'(b_q >> shamt);
  assign sum_c   = {1'b0, a_chunk} + {1'b0, b_chunk} + KW1'(carry_q);

  // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    carry_d = carry_q;
    j_d     = j_q;
    data_d  = data_q;
    over_d  = over_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = data0_i;
          b_d     = data1_i;
          sign_d  = sign_i;
          carry_d = 1'b0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        data_d  = (data_q & ~(CHUNK_MASK << shamt)) | (N'(sum_c[K-1:0]) << shamt);
        carry_d = sum_c[K];
        if (j_q == J_LAST) begin
          // sum_c[K-1] is result bit N-1 on the last chunk.
          over_d  = sign_q ? ((a_q[N-1] == b_q[N-1]) && (sum_c[K-1] != a_q[N-1]))
                           : sum_c[K];
          state_d = S_DONE;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      j_q     <= '0;
      data_q  <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      j_q     <= j_d;
      data_q  <= data_d;
      over_q  <= over_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign data_o  = data_q;
  assign over_o  = over_q;

endmodule

// File: tb/tb_add_seq_n.sv
// Directed bench for add_seq_n: three instances (K=4, K=1, K=8, N=8) share stimulus
// and are checked against hand-computed sums, overflow flags and latencies.
module tb_add_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sign;
  logic [7:0] data0, data1;
  logic [2:0] ready, valid, over;
  logic [7:0] dout [3];

  int n_pass  = 0;
  int n_total = 0;

  // Expected cycles from accept edge to valid, and accept spacing, for K = 4, 1, 8.
  int lat_exp [3] = '{2, 8, 1};
  int gap_exp [3] = '{4, 10, 3};
  int kval    [3] = '{4, 1, 8};

  int         lat [3];
  int         pulses [3];
  logic       rdy_run [3];
  logic [7:0] got_d [3];
  logic       got_o [3];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] d;
    logic       o;
  } vec_t;

  vec_t vecs [8] = '{
    '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1},
    '{8'h7F, 8'h01, 1'b1, 8'h80, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0},
    '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1},
    '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0},
    '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1},
    '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0}
  };

  add_seq_n #(.N(8), .K(4)) u_k4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sign_i(sign),
    .data0_i(data0), .data1_i(data1),
    .ready_o(ready[0]), .valid_o(valid[0]), .data_o(dout[0]), .over_o(over[0])
  );
  add_seq_n #(.N(8), .K(1)) u_k1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sign_i(sign),
    .data0_i(data0), .data1_i(data1),
    .ready_o(ready[1]), .valid_o(valid[1]), .data_o(dout[1]), .over_o(over[1])
  );
  add_seq_n #(.N(8), .K(8)) u_k8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sign_i(sign),
    .data0_i(data0), .data1_i(data1),
    .ready_o(ready[2]), .valid_o(valid[2]), .data_o(dout[2]), .over_o(over[2])
  );

  // One start pulse, scrambled inputs after accept, then 12 bounded cycles of observation.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(posedge clk); #1;
    data0 = a; data1 = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data0 = ~a; data1 = a ^ b ^ 8'h5A; sign = ~s;
    for (int d = 0; d < 3; d++) begin
      lat[d] = -1; pulses[d] = 0; rdy_run[d] = 1'bx; got_d[d] = 8'hxx; got_o[d] = 1'bx;
    end
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (i == 1) rdy_run[d] = ready[d];
        if (valid[d] === 1'b1) begin
          pulses[d]++;
          if (lat[d] < 0) begin
            lat[d] = i; got_d[d] = dout[d]; got_o[d] = over[d];
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; sign = 1'b0; data0 = 8'hFF; data1 = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if ({ready[d], valid[d], dout[d], over[d]} !== {1'b1, 1'b0, 8'h00, 1'b0})
        $display("FAIL reset K=%0d: rdy/val/data/over=%b/%b/%h/%b want 1/0/00/0",
                 kval[d], ready[d], valid[d], dout[d], over[d]);
      else n_pass++;
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_vectors;
    foreach (vecs[v]) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].s);
      for (int d = 0; d < 3; d++) begin
        n_total++;
        if (got_d[d] !== vecs[v].d)
          $display("FAIL sum K=%0d %h+%h s=%b: got %h want %h",
                   kval[d], vecs[v].a, vecs[v].b, vecs[v].s, got_d[d], vecs[v].d);
        else n_pass++;
        n_total++;
        if (got_o[d] !== vecs[v].o)
          $display("FAIL over K=%0d %h+%h s=%b: got %b want %b",
                   kval[d], vecs[v].a, vecs[v].b, vecs[v].s, got_o[d], vecs[v].o);
        else n_pass++;
        n_total++;
        if (lat[d] != lat_exp[d] || pulses[d] != 1)
          $display("FAIL latency K=%0d: got lat %0d pulses %0d want lat %0d pulses 1",
                   kval[d], lat[d], pulses[d], lat_exp[d]);
        else n_pass++;
        n_total++;
        if (rdy_run[d] !== 1'b0)
          $display("FAIL ready_busy K=%0d: got %b want 0", kval[d], rdy_run[d]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int vc [3][2];
    int cnt [3];
    logic [7:0] last_d [3];
    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0; vc[d][0] = -1; vc[d][1] = -1; last_d[d] = 8'hxx;
    end
    @(posedge clk); #1;
    data0 = 8'h12; data1 = 8'h34; sign = 1'b0; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (valid[d] === 1'b1) begin
          if (cnt[d] < 2) vc[d][cnt[d]] = c;
          cnt[d]++;
          last_d[d] = dout[d];
        end
      end
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (vc[d][0] < 0 || vc[d][1] - vc[d][0] != gap_exp[d])
        $display("FAIL b2b_gap K=%0d: got %0d want %0d", kval[d], vc[d][1] - vc[d][0], gap_exp[d]);
      else n_pass++;
      n_total++;
      if (last_d[d] !== 8'h46)
        $display("FAIL b2b_sum K=%0d: got %h want 46", kval[d], last_d[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run;
    int late [3];
    @(posedge clk); #1;
    data0 = 8'hAA; data1 = 8'h55; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if ({ready[d], valid[d], dout[d], over[d]} !== {1'b1, 1'b0, 8'h00, 1'b0})
        $display("FAIL midrun_reset K=%0d: rdy/val/data/over=%b/%b/%h/%b want 1/0/00/0",
                 kval[d], ready[d], valid[d], dout[d], over[d]);
      else n_pass++;
      late[d] = 0;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 3; d++) if (valid[d] === 1'b1) late[d]++;
    end
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (late[d] != 0)
        $display("FAIL midrun_no_valid K=%0d: got %0d pulses want 0", kval[d], late[d]);
      else n_pass++;
    end
    run_op(8'hAA, 8'h55, 1'b0);
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (got_d[d] !== 8'hFF || got_o[d] !== 1'b0 || lat[d] != lat_exp[d])
        $display("FAIL post_reset K=%0d: got %h/%b lat %0d want FF/0 lat %0d",
                 kval[d], got_d[d], got_o[d], lat[d], lat_exp[d]);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sign = 1'b0; data0 = '0; data1 = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/add_seq_n.md
Name: add_seq_n

Overview:
- Multi-cycle N-bit adder; the addition-side counterpart of the team's N-bit subtractor.
- Adds two operands K bits per clock, with a registered carry chained between chunks.
- Supports unsigned and two's-complement modes and reports overflow.
- Sits in the datapath library beside the subtractor and is driven by a start/ready handshake from a controller.

Parameters:
- N, 8, operand and result width; must be a multiple of K.
- K, 4, chunk width added per cycle; 1 <= K <= N.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted when start_i && ready_o at a rising edge.
- sign_i  input  1  0 = unsigned, 1 = two's-complement; sampled at accept.
- data0_i  input  N  addend A; sampled at accept.
- data1_i  input  N  addend B; sampled at accept.
- ready_o  output  1  high only in IDLE.
- valid_o  output  1  one-cycle pulse; result valid.
- data_o  output  N  sum[N-1:0].
- over_o  output  1  overflow flag (rules below).

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE; ready_o=1, valid_o=0, data_o=0, over_o=0.
  - Chunk counter, carry register and operand registers are cleared.
  - Reset overrides everything, including mid-RUN and a simultaneous start_i.
- Clock/reset: single clock domain only; rst_i is sampled only at clock edges.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On start_i=1: latch data0_i, data1_i and sign_i; carry<=0; chunk index j<=0; go to RUN.
  - data_o and over_o keep their previous values until the first RUN chunk write.
- RUN (ready_o=0):
  - Each edge computes {c, s} = A[jK+K-1:jK] + B[jK+K-1:jK] + carry.
  - Writes data_o[jK+K-1:jK] <= s and carry <= c.
  - If j = N/K-1: compute over_o and go to DONE; otherwise j <= j+1.
- Overflow rule:
  - Unsigned: over_o = final carry out of bit N-1.
  - Signed: over_o = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]).
- DONE:
  - valid_o=1 for exactly this cycle; ready_o=0.
  - Next edge goes to IDLE.
  - data_o and over_o hold until bits are overwritten by the next operation's RUN.
- Latency: accept at edge t, last chunk at edge t+N/K, valid_o high during cycle t+N/K (after that edge). ready_o returns high after edge t+N/K+1. Throughput is one op per N/K+2 cycles.
- Input changes on data*_i and sign_i after accept have no effect.
- start_i while ready_o=0 is ignored; it is not queued.
- K = N: single RUN cycle.
- K = 1: fully bit-serial, N RUN cycles.
- Result data_o always equals (A+B) mod 2^N, regardless of sign_i.

Test Plan:
- N=8,K=4, unsigned: A=0xC8 (200), B=0x64 (100) -> data_o=0x2C, over_o=1, valid_o pulses exactly 2 cycles after the accept edge.
- Signed: A=0x7F, B=0x01 -> data_o=0x80, over_o=1. Same operands unsigned -> over_o=0.
- Signed: A=0xFF, B=0x01 -> data_o=0x00, over_o=0. Unsigned same operands -> data_o=0x00, over_o=1.
- Carry across chunk boundary: unsigned A=0x0F, B=0x01 -> data_o=0x10, over_o=0. Signed A=0x80, B=0x80 -> data_o=0x00, over_o=1.
- Handshake: hold start_i=1 continuously -> accepts spaced exactly N/K+2 cycles apart. Changing data0_i during RUN does not alter data_o.
- Reset mid-RUN: assert rst_i during the first RUN cycle -> next cycle ready_o=1, valid_o=0, data_o=0, over_o=0, and no valid_o pulse follows. Repeat with K=1 and K=8 for 0xAA+0x55 -> 0xFF, over_o=0.
